// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for memory port B: round-robin on ties,
// ROM-write rejection, BUSY timeout, and per-requester registered responses.
module mem_port_arbiter #(
  parameter logic [31:0] ROM_UPPER_ADDR = 32'h7fff_ffff,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_isRequest,
  input  logic [3:0]  req0_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_din,
  output logic [31:0] req0_dout,
  output logic        req0_requestDone,
  output logic        req0_error,
  input  logic        req1_isRequest,
  input  logic [3:0]  req1_we,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_din,
  output logic [31:0] req1_dout,
  output logic        req1_requestDone,
  output logic        req1_error,
  output logic        mem_isRequestB,
  output logic [3:0]  mem_weB,
  output logic [31:0] mem_addrB,
  output logic [31:0] mem_dinB,
  input  logic [31:0] mem_doutB,
  input  logic        mem_requestDoneB
);

  localparam bit          LP_TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_owner;
  logic [15:0] r_cnt;
  logic [3:0]  r_we;
  logic [31:0] r_addr;
  logic [31:0] r_din;
  logic        r_mem_req;
  logic [1:0]  r_done;
  logic [1:0]  r_err;
  logic [31:0] r_dout [2];

  logic        w_elig0;
  logic        w_elig1;
  logic        w_grant;
  logic [3:0]  w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_din;
  logic        w_rom_wr;

  // A requester whose done pulse is on the bus this cycle is not re-granted on a stale request.
  assign w_elig0    = req0_isRequest & ~r_done[0];
  assign w_elig1    = req1_isRequest & ~r_done[1];
  assign w_grant    = (w_elig0 & w_elig1) ? ~r_last : w_elig1;
  assign w_sel_we   = w_grant ? req1_we   : req0_we;
  assign w_sel_addr = w_grant ? req1_addr : req0_addr;
  assign w_sel_din  = w_grant ? req1_din  : req0_din;
  assign w_rom_wr   = (w_sel_we != 4'b0000) && (w_sel_addr <= ROM_UPPER_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_owner   <= 1'b0;
      r_cnt     <= '0;
      r_we      <= '0;
      r_addr    <= '0;
      r_din     <= '0;
      r_mem_req <= 1'b0;
      r_done    <= '0;
      r_err     <= '0;
      r_dout[0] <= '0;
      r_dout[1] <= '0;
    end else begin
      r_done    <= '0;
      r_err     <= '0;
      r_dout[0] <= '0;
      r_dout[1] <= '0;
      case (r_state)
        IDLE: begin
          if (w_elig0 | w_elig1) begin
            r_owner <= w_grant;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_din   <= w_sel_din;
            if (w_rom_wr) begin
              r_state         <= RESP;
              r_done[w_grant] <= 1'b1;
              r_err[w_grant]  <= 1'b1;
            end else begin
              r_state   <= BUSY;
              r_mem_req <= 1'b1;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + 16'd1;
          // Completion outranks a timeout landing in the same cycle.
          if (mem_requestDoneB) begin
            r_state         <= RESP;
            r_mem_req       <= 1'b0;
            r_done[r_owner] <= 1'b1;
            r_dout[r_owner] <= mem_doutB;
          end else if (LP_TO_EN && (r_cnt == LP_TO_LAST)) begin
            r_state         <= RESP;
            r_mem_req       <= 1'b0;
            r_done[r_owner] <= 1'b1;
            r_err[r_owner]  <= 1'b1;
          end
        end
        RESP: begin
          r_last  <= r_owner;
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req0_requestDone = r_done[0];
  assign req0_error       = r_err[0];
  assign req0_dout        = r_dout[0];
  assign req1_requestDone = r_done[1];
  assign req1_error       = r_err[1];
  assign req1_dout        = r_dout[1];
  assign mem_isRequestB   = r_mem_req;
  assign mem_weB          = r_we;
  assign mem_addrB        = r_addr;
  assign mem_dinB         = r_din;

endmodule
